// File: rtl/counter_checker_pkg.sv
// Shared FSM state encoding and default parameters for the counter_checker monitor.
package counter_checker_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_LOCK_CYCLES = 4;
  localparam int DEF_STAT_W      = 16;

endpackage

// File: rtl/counter_checker_sat_counter.sv
// Saturating statistics counter with synchronous clear; clear has priority over increment.
module sat_counter
  import counter_checker_pkg::*;
#(
  parameter int W = DEF_STAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/counter_checker.sv
// Receive-side monitor for a free-running counter: locks on a +1 stream and reports breaks.
// Optional macro COUNTER_CHECKER_HOLD_TOL_EN accepts a repeated value while locked as a stall.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int STAT_W      = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              clear,
  output logic              locked,
  output logic              error_pulse,
  output logic              sticky_error,
  output logic [STAT_W-1:0] error_count,
  output logic [STAT_W-1:0] wrap_count
`ifdef COUNTER_CHECKER_HOLD_TOL_EN
  ,
  output logic [STAT_W-1:0] hold_count
`endif
);

  localparam logic [3:0]       LP_LOCK = 4'(LOCK_CYCLES);
  localparam logic [WIDTH-1:0] LP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [3:0]       r_match_cnt;
  logic             r_locked;
  logic             r_error_pulse;
  logic             r_sticky;

  logic [WIDTH-1:0] w_expected;
  logic [3:0]       w_match_next;
  logic             w_match;
  logic             w_chk_locked;
  logic             w_hold;
  logic             w_err;
  logic             w_wrap;

  // Natural WIDTH-bit truncation makes all-ones followed by zero a legal increment.
  assign w_expected   = r_prev + LP_ONE;
  assign w_match      = (count_in == w_expected);
  assign w_match_next = r_match_cnt + 4'd1;
  assign w_chk_locked = enable && (r_state == LOCKED);

`ifdef COUNTER_CHECKER_HOLD_TOL_EN
  assign w_hold = w_chk_locked && (count_in == r_prev);
`else
  assign w_hold = 1'b0;
`endif

  assign w_err  = w_chk_locked && !w_match && !w_hold;
  assign w_wrap = w_chk_locked && w_match && (r_prev == {WIDTH{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= EMPTY;
      r_prev        <= '0;
      r_match_cnt   <= '0;
      r_locked      <= 1'b0;
      r_error_pulse <= 1'b0;
    end else begin
      r_error_pulse <= 1'b0;
      if (enable) begin
        r_prev <= count_in;
        case (r_state)
          EMPTY: begin
            r_match_cnt <= '0;
            r_state     <= ACQUIRE;
          end
          ACQUIRE: begin
            if (w_match) begin
              r_match_cnt <= w_match_next;
              if (w_match_next == LP_LOCK) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (w_err) begin
              r_error_pulse <= 1'b1;
              r_locked      <= 1'b0;
              r_match_cnt   <= '0;
              r_state       <= ACQUIRE;
            end
          end
          default: begin
            r_state  <= EMPTY;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Clear beats a same-edge mismatch for the sticky flag; the pulse is unaffected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sticky <= 1'b0;
    end else if (clear) begin
      r_sticky <= 1'b0;
    end else if (w_err) begin
      r_sticky <= 1'b1;
    end
  end

  sat_counter #(.W(STAT_W)) u_error_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_err),
    .clr   (clear),
    .cnt   (error_count)
  );

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_wrap),
    .clr   (clear),
    .cnt   (wrap_count)
  );

`ifdef COUNTER_CHECKER_HOLD_TOL_EN
  sat_counter #(.W(STAT_W)) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hold),
    .clr   (clear),
    .cnt   (hold_count)
  );
`endif

  assign locked       = r_locked;
  assign error_pulse  = r_error_pulse;
  assign sticky_error = r_sticky;

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receive-side monitor for the free-running `counter` block. It is the reader for that writer.
- Samples the counter's output bus and checks that each sample is previous+1, modulo 2^WIDTH.
- Acquires lock on the stream, then reports mismatches, error counts and wrap events.
- Sits beside `counter` in the lab top level and in its bench; can also be used as a synthesizable self-check.

Parameters:
- WIDTH, 8, width of the observed count bus.
- LOCK_CYCLES, 4, consecutive correct increments required to declare lock (range 1..15).
- STAT_W, 16, width of the error and wrap statistic counters.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- enable  input  1  sample-valid qualifier; count_in is evaluated only when 1.
- count_in  input  WIDTH  observed counter value.
- clear  input  1  synchronous clear of statistics and sticky flag.
- locked  output  1  stream is locked and being checked.
- error_pulse  output  1  one-cycle strobe on a mismatch while locked.
- sticky_error  output  1  set on any locked mismatch; held until clear or reset.
- error_count  output  STAT_W  saturating count of locked mismatches.
- wrap_count  output  STAT_W  saturating count of locked all-ones to 0 transitions.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=EMPTY.
  - All outputs 0: locked, error_pulse, sticky_error, error_count, wrap_count.
  - Internal prev and match_cnt = 0.
  - Reset asserted mid-operation clears everything immediately. No lock carries over.
- enable=0: no compare; prev, match_cnt and state hold; error_pulse=0.
- Match condition: count_in == prev+1, truncated to WIDTH bits. prev=2^WIDTH-1 followed by 0 is a match.
- All outputs are registered. Latency is one clock from the sampling edge to the output update.
- FSM, evaluated only on edges with enable=1:
  - EMPTY: load prev=count_in; match_cnt=0; go to ACQUIRE.
  - ACQUIRE:
    - Match: match_cnt++. When match_cnt reaches LOCK_CYCLES, go to LOCKED and set locked=1.
    - Mismatch: match_cnt=0. No error is reported.
    - prev=count_in in both cases.
  - LOCKED:
    - Match: stay in LOCKED. If prev is all-ones and count_in=0, wrap_count++ (saturating at 2^STAT_W-1).
    - Mismatch: error_pulse=1 for exactly one cycle; error_count++ (saturating); sticky_error=1; locked=0; match_cnt=0; go to ACQUIRE.
    - prev=count_in in both cases.
- clear=1 on an edge:
  - error_count=0, wrap_count=0, sticky_error=0. FSM and lock state are unaffected.
  - clear and a mismatch on the same edge: clear wins for the statistics (count=0, sticky=0), but error_pulse still fires.
- Saturated counters hold at their maximum; no rollover.
- LOCK_CYCLES=1: the first match after EMPTY or a mismatch locks.

Optional Feature:
- Macro: COUNTER_CHECKER_HOLD_TOL_EN.
- Defined: in LOCKED, count_in == prev is accepted as a legal stall. No error is raised, state is unchanged, and a hold_count output (STAT_W, saturating, cleared by clear/reset) increments.
- Undefined: a repeated value is an ordinary mismatch, and the hold_count port does not exist.

Decomposition:
- Package counter_checker_pkg:
  - FSM state encoding: EMPTY=2'd0, ACQUIRE=2'd1, LOCKED=2'd2.
  - Default constants for WIDTH, LOCK_CYCLES and STAT_W.
- One sub-module, sat_counter (parameter W; inputs inc and clr; output cnt; async active-low reset).
  - Instantiated for error_count, wrap_count and, when the feature is compiled in, hold_count.

Test Plan:
1. Reset=0 for 100 ns, then release. Stream 0x00,0x01,0x02,0x03,0x04 with enable=1 -> locked=1 one clock after the edge sampling 0x04; error_count=0.
2. Locked stream 0xFE,0xFF,0x00,0x01 -> no error_pulse; wrap_count=1; locked stays 1.
3. Locked stream 0x10,0x11,0x13 -> error_pulse high one cycle; error_count=1; sticky_error=1; locked=0. Continue 0x14..0x17 -> locked=1 again after sampling 0x17.
4. Locked at 0x20, then enable=0 for 5 cycles with count_in held at 0x20; enable=1 with 0x21 -> no error; locked stays 1.
5. Locked mismatch and clear=1 on the same edge -> error_pulse=1; error_count=0; sticky_error=0.
6. Assert reset while locked with error_count=3 -> all outputs 0 before the next clk edge. After release, lock requires LOCK_CYCLES fresh matches.
